// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Steps the north-south / east-west signal heads through a fixed phase cycle.
// The cycle includes an optional pedestrian walk phase and a night flash mode.
// Each phase is timed by a two-digit BCD down-counter. The counter advances
// on the 1 Hz tick enable. Its digits go straight to the seven-segment
// decoders.
//
// Ports
//   CLOCK_50    in   1  system clock (only clock)
//   reset       in   1  asynchronous active-high reset
//   tick        in   1  1 Hz single-cycle enable, synchronous to CLOCK_50
//   ped_req     in   1  pedestrian request level, sampled every cycle
//   night       in   1  night flash mode select
//   light_ns    out  3  {red, yellow, green} north-south
//   light_ew    out  3  {red, yellow, green} east-west
//   walk        out  1  walk lamp
//   digit_tens  out  4  remaining seconds, BCD tens
//   digit_ones  out  4  remaining seconds, BCD ones
//   phase       out  3  current state code
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int GREEN_NS_S = 20,
  parameter int GREEN_EW_S = 15,
  parameter int YELLOW_S   = 3,
  parameter int ALLRED_S   = 2,
  parameter int WALK_S     = 10
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       walk,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_ones,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED1  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED2  = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  function automatic logic [7:0] to_bcd(input int d);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((d / 10) % 10);
    o = 4'(d % 10);
    return {t, o};
  endfunction

  localparam logic [7:0] BCD_GREEN_NS = to_bcd(GREEN_NS_S);
  localparam logic [7:0] BCD_GREEN_EW = to_bcd(GREEN_EW_S);
  localparam logic [7:0] BCD_YELLOW   = to_bcd(YELLOW_S);
  localparam logic [7:0] BCD_ALLRED   = to_bcd(ALLRED_S);
  localparam logic [7:0] BCD_WALK     = to_bcd(WALK_S);

  function automatic logic [7:0] duration_of(input state_t s);
    case (s)
      NS_GREEN:             return BCD_GREEN_NS;
      EW_GREEN:             return BCD_GREEN_EW;
      NS_YELLOW, EW_YELLOW: return BCD_YELLOW;
      ALL_RED1, ALL_RED2:   return BCD_ALLRED;
      PED_WALK:             return BCD_WALK;
      default:              return 8'h00;   // FLASH shows 00
    endcase
  endfunction

  state_t     state_reg, state_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] ones_reg, ones_next;
  logic       ped_pending_reg, ped_pending_next;
  logic       flash_reg, flash_next;
  logic [2:0] light_ns_next, light_ew_next;
  logic       walk_next;

  logic       ped_eff;
  logic       last_second;

  always_comb begin
    state_next  = state_reg;
    tens_next   = tens_reg;
    ones_next   = ones_reg;
    flash_next  = flash_reg;

    // A request in the same cycle as the ALL_RED2 boundary must still be
    // honoured, so the live request is merged in here. Requests are not
    // only latched for later.
    ped_eff     = ped_pending_reg |
                  (ped_req & (state_reg != PED_WALK) & (state_reg != FLASH));
    last_second = (tens_reg == 4'd0) && (ones_reg == 4'd1);

    if (tick) begin
      if (state_reg == FLASH) begin
        flash_next = ~flash_reg;
        if (!night) begin
          state_next             = ALL_RED2;
          {tens_next, ones_next} = BCD_ALLRED;
          flash_next             = 1'b0;
        end
      end else if (last_second) begin
        case (state_reg)
          NS_GREEN:  state_next = NS_YELLOW;
          NS_YELLOW: state_next = ALL_RED1;
          ALL_RED1:  state_next = EW_GREEN;
          EW_GREEN:  state_next = EW_YELLOW;
          EW_YELLOW: state_next = ALL_RED2;
          ALL_RED2: begin
            if (night)        state_next = FLASH;
            else if (ped_eff) state_next = PED_WALK;
            else              state_next = NS_GREEN;
          end
          PED_WALK:  state_next = night ? FLASH : NS_GREEN;
          default:   state_next = NS_GREEN;
        endcase
        {tens_next, ones_next} = duration_of(state_next);
        if (state_next == FLASH) flash_next = 1'b1;
      end else if (ones_reg == 4'd0) begin
        ones_next = 4'd9;
        tens_next = tens_reg - 4'd1;
      end else begin
        ones_next = ones_reg - 4'd1;
      end
    end

    // Entering walk or flash consumes any pending request. While in those
    // states ped_eff ignores the button, so the flag stays clear.
    ped_pending_next = ped_eff;
    if (state_next == PED_WALK || state_next == FLASH) ped_pending_next = 1'b0;

    // Lamp decode is computed from next state so the lamps register together
    // with the state and stay in step with it.
    light_ns_next = LAMP_RED;
    light_ew_next = LAMP_RED;
    case (state_next)
      NS_GREEN:  light_ns_next = LAMP_GRN;
      NS_YELLOW: light_ns_next = LAMP_YEL;
      EW_GREEN:  light_ew_next = LAMP_GRN;
      EW_YELLOW: light_ew_next = LAMP_YEL;
      FLASH: begin
        light_ns_next = {1'b0, flash_next, 1'b0};
        light_ew_next = {flash_next, 2'b00};
      end
      default: ;
    endcase
    walk_next = (state_next == PED_WALK);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg       <= ALL_RED2;
      tens_reg        <= BCD_ALLRED[7:4];
      ones_reg        <= BCD_ALLRED[3:0];
      ped_pending_reg <= 1'b0;
      flash_reg       <= 1'b0;
      light_ns        <= LAMP_RED;
      light_ew        <= LAMP_RED;
      walk            <= 1'b0;
    end else begin
      state_reg       <= state_next;
      tens_reg        <= tens_next;
      ones_reg        <= ones_next;
      ped_pending_reg <= ped_pending_next;
      flash_reg       <= flash_next;
      light_ns        <= light_ns_next;
      light_ew        <= light_ew_next;
      walk            <= walk_next;
    end
  end

  assign phase      = state_reg;
  assign digit_tens = tens_reg;
  assign digit_ones = ones_reg;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//
// Directed bench for traffic_phase_sequencer with default durations
// (20/15/3/2/10 s). Inputs change on the falling edge. Outputs are sampled on
// the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

  logic       CLOCK_50;
  logic       reset;
  logic       tick;
  logic       ped_req;
  logic       night;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic       walk;
  logic [3:0] digit_tens;
  logic [3:0] digit_ones;
  logic [2:0] phase;

  int tests_run = 0;
  int tests_failed = 0;
  logic walk_seen = 1'b0;

  traffic_phase_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .tick       (tick),
    .ped_req    (ped_req),
    .night      (night),
    .light_ns   (light_ns),
    .light_ew   (light_ew),
    .walk       (walk),
    .digit_tens (digit_tens),
    .digit_ones (digit_ones),
    .phase      (phase)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] ph, input logic [7:0] dig,
                         input logic [2:0] ns, input logic [2:0] ew, input logic w);
    chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
    chk({tag, ".digits"}, {digit_tens, digit_ones}, dig);
    chk({tag, ".light_ns"}, {5'd0, light_ns}, {5'd0, ns});
    chk({tag, ".light_ew"}, {5'd0, light_ew}, {5'd0, ew});
    chk({tag, ".walk"}, {7'd0, walk}, {7'd0, w});
    $display("[TB] %s: phase=%0d digits=%0d%0d ns=%b ew=%b walk=%b",
             tag, phase, digit_tens, digit_ones, light_ns, light_ew, walk);
  endtask

  task automatic do_tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
      tick = 1'b1;
      @(negedge CLOCK_50);
      tick = 1'b0;
      walk_seen = walk_seen | walk;
    end
  endtask

  task automatic ped_pulse();
    @(negedge CLOCK_50);
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    ped_req = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    ped_req = 1'b0;
    night   = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    chk_all("reset", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    reset = 1'b0;

    // Startup: ALL_RED2 runs out, then NS_GREEN
    do_tick(1);
    chk_all("start_t1", 3'd5, 8'h01, 3'b100, 3'b100, 1'b0);
    do_tick(1);
    chk_all("start_t2", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);

    // BCD borrow and full cycle with no requests
    walk_seen = 1'b0;
    do_tick(1);
    chk_all("borrow_19", 3'd0, 8'h19, 3'b001, 3'b100, 1'b0);
    do_tick(9);
    chk_all("at_10", 3'd0, 8'h10, 3'b001, 3'b100, 1'b0);
    do_tick(1);
    chk_all("borrow_09", 3'd0, 8'h09, 3'b001, 3'b100, 1'b0);
    do_tick(8);
    chk_all("ns_last", 3'd0, 8'h01, 3'b001, 3'b100, 1'b0);
    do_tick(1);
    chk_all("ns_yellow", 3'd1, 8'h03, 3'b010, 3'b100, 1'b0);
    do_tick(3);
    chk_all("all_red1", 3'd2, 8'h02, 3'b100, 3'b100, 1'b0);
    do_tick(2);
    chk_all("ew_green", 3'd3, 8'h15, 3'b100, 3'b001, 1'b0);
    do_tick(15);
    chk_all("ew_yellow", 3'd4, 8'h03, 3'b100, 3'b010, 1'b0);
    do_tick(3);
    chk_all("all_red2", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    do_tick(2);
    chk_all("cycle_back", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);
    chk("cycle_no_walk", {7'd0, walk_seen}, 8'h00);

    // Pedestrian request during EW_GREEN; second pulse in PED_WALK discarded
    do_tick(27);
    chk_all("ped_ewg", 3'd3, 8'h13, 3'b100, 3'b001, 1'b0);
    ped_pulse();
    do_tick(16);
    chk_all("ped_ar2", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    do_tick(2);
    chk_all("ped_walk", 3'd6, 8'h10, 3'b100, 3'b100, 1'b1);
    ped_pulse();
    do_tick(9);
    chk_all("ped_walk_last", 3'd6, 8'h01, 3'b100, 3'b100, 1'b1);
    do_tick(1);
    chk_all("ped_to_nsg", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);
    walk_seen = 1'b0;
    do_tick(45);
    chk_all("ped_discarded", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);
    chk("ped_discarded_walk", {7'd0, walk_seen}, 8'h00);

    // Request arriving in the same cycle as the ALL_RED2 boundary tick
    do_tick(44);
    chk_all("same_ar2", 3'd5, 8'h01, 3'b100, 3'b100, 1'b0);
    @(negedge CLOCK_50);
    tick    = 1'b1;
    ped_req = 1'b1;
    @(negedge CLOCK_50);
    tick    = 1'b0;
    ped_req = 1'b0;
    chk_all("same_walk", 3'd6, 8'h10, 3'b100, 3'b100, 1'b1);
    do_tick(10);
    chk_all("same_nsg", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);

    // Night mode requested mid EW_GREEN
    do_tick(27);
    @(negedge CLOCK_50);
    night = 1'b1;
    do_tick(1);
    chk_all("night_mid", 3'd3, 8'h12, 3'b100, 3'b001, 1'b0);
    do_tick(15);
    chk_all("night_ar2", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    do_tick(2);
    chk_all("flash_on", 3'd7, 8'h00, 3'b010, 3'b100, 1'b0);
    do_tick(1);
    chk_all("flash_off", 3'd7, 8'h00, 3'b000, 3'b000, 1'b0);
    do_tick(1);
    chk_all("flash_on2", 3'd7, 8'h00, 3'b010, 3'b100, 1'b0);
    @(negedge CLOCK_50);
    night = 1'b0;
    do_tick(1);
    chk_all("flash_exit", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    do_tick(2);
    chk_all("flash_nsg", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);

    // Async reset mid EW_YELLOW clears a pending request
    do_tick(25);
    ped_pulse();
    do_tick(15);
    chk_all("rst_pre", 3'd4, 8'h03, 3'b100, 3'b010, 1'b0);
    @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1;
    chk_all("rst_async", 3'd5, 8'h02, 3'b100, 3'b100, 1'b0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    do_tick(1);
    chk_all("rst_t1", 3'd5, 8'h01, 3'b100, 3'b100, 1'b0);
    do_tick(1);
    chk_all("rst_no_walk", 3'd0, 8'h20, 3'b001, 3'b100, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
